counter_read_ctrl: RTL and testbench
====================================

// Module: counter_read_ctrl
// PURPOSE
//   Bus-side read master for the 64-bit atomic event counter. On a start pulse it issues the
//   two-beat read: beat 0 with atomic asserted, then beat 1 with atomic deasserted. It
//   assembles the 64-bit snapshot from the two 32-bit responses and reports it together with
//   the modulo-2^64 delta since the previous good read. Sits between the microcontroller's
//   sampling logic and the counter's req/ack port.
// PARAMETERS
//   ACK_TIMEOUT  4   cycles after req_o with no ack_i before the read aborts (>=1)
//   CNT_W        64  assembled counter width; must equal 2*BUS_W
//   BUS_W        32  counter bus data width
// PORTS
//   clk          in   1      clock; all flops rising-edge
//   reset        in   1      asynchronous, active-high reset
//   rd_start_i   in   1      start one 64-bit read; sampled only in IDLE
//   rd_busy_o    out  1      high whenever state != IDLE
//   req_o        out  1      read request to counter; registered, 1-cycle pulse per beat
//   atomic_o     out  1      high with req_o on beat 0 only; registered
//   ack_i        in   1      counter acknowledge (nominally 1 cycle after req_o)
//   count_i      in   BUS_W  counter data, valid when ack_i=1
//   val_valid_o  out  1      1-cycle pulse: val_o/delta_o updated
//   val_o        out  CNT_W  last assembled value {hi,lo}; held until next good read
//   delta_o      out  CNT_W  val_o - previous val_o, mod 2^CNT_W; held
//   err_o        out  1      1-cycle pulse on ack timeout (read aborted)
// BEHAVIOUR
//   Reset: all outputs 0. State=IDLE. prev value=0. Async assert drops req_o in the same cycle.
//   FSM (registered outputs):
//     IDLE    : rd_start_i -> REQ_LO
//     REQ_LO  : req_o=1, atomic_o=1 for one cycle; timer cleared -> WAIT_LO
//     WAIT_LO : ack_i -> capture lo=count_i -> REQ_HI; timer==ACK_TIMEOUT -> ERR
//     REQ_HI  : req_o=1, atomic_o=0 for one cycle -> WAIT_HI
//     WAIT_HI : ack_i -> capture hi=count_i -> DONE; timer==ACK_TIMEOUT -> ERR
//     DONE    : val_o<={hi,lo}; delta_o<={hi,lo}-prev; prev<={hi,lo}; val_valid_o=1 -> IDLE
//     ERR     : err_o=1; val_o, delta_o, prev unchanged -> IDLE
//   Nominal latency: start sampled at edge T; req atomic in T+1; ack T+2; req hi in T+3;
//     ack T+4; val_valid_o high in T+5. The next start is accepted in T+6 (6-cycle throughput).
//   The timer counts cycles in WAIT_* without ack_i. An ack on the same cycle the timer hits
//     ACK_TIMEOUT wins (the capture is taken).
//   ack_i seen in IDLE, REQ_*, DONE or ERR is ignored; no capture and no error.
//   rd_start_i while busy is dropped (not queued); the controller must poll rd_busy_o.
//   Delta is plain modulo subtraction, so a 64-bit counter wrap yields the correct small delta.
//     The first read after reset yields delta == value.
//   The beat-0 response is the low word. The beat-1 response is the upper word that the
//     counter snapshotted at beat 0. The block never reorders or retries beats.
//   Reset mid-read: abort immediately, no val_valid_o/err_o pulse; prev returns to 0.
// STRUCTURE
//   Package counter_rd_pkg: state_e enum {IDLE,REQ_LO,WAIT_LO,REQ_HI,WAIT_HI,DONE,ERR};
//     localparams BUS_W=32, CNT_W=64.
//   Sub-module ack_timer: clear/enable/expire counter sized $clog2(ACK_TIMEOUT+1).
//   Top level holds the FSM, lo/hi capture regs, prev/val/delta regs and the 64-bit subtractor.
// TESTING
//   1 Counter preloaded 0x0000_0001_FFFF_FFFE, trig every cycle, pulse start ->
//     val_o=0x0000_0001_FFFF_FFFE...0x0000_0002_0000_00xx atomic (hi==snapshot), never torn.
//   2 Two reads of an idle counter at 0x10 then 0x35 ->
//     1st delta_o=0x10; 2nd val_o=0x35, delta_o=0x25.
//   3 prev=0xFFFF_FFFF_FFFF_FFF0, next read 0x0000_0000_0000_0005 -> delta_o=0x15.
//   4 ack_i held low after REQ_LO, ACK_TIMEOUT=4 -> err_o pulse 5 cycles after req_o;
//     val_o unchanged; rd_busy_o low.
//   5 rd_start_i held high for 20 cycles -> exactly 3 complete reads (cycle 6 throughput),
//     req_o/atomic_o pattern 1/1,1/0 per read.
//   6 reset asserted in WAIT_HI -> req_o, rd_busy_o, val_o 0 at once;
//     a fresh start after release completes normally with delta==value.

Source files
------------

// File: rtl/counter_read_ctrl_pkg.sv
// Shared types and widths for the two-beat 64-bit counter read master.
package counter_rd_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned CNT_W = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_e;

endpackage

// File: rtl/counter_read_ctrl_ack_timer.sv
// Acknowledge watchdog: counts ack-less wait cycles, expires on the last allowed one.
module ack_timer #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] ONE  = TW'(1);

  logic [TW-1:0] count_r;

  // The current cycle counts toward the limit, so expiry fires on the TIMEOUT-th idle cycle.
  assign expire = enable && (count_r == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/counter_read_ctrl.sv
// Two-beat atomic read master: issues lo/hi beats, assembles the 64-bit snapshot, reports delta.
module counter_read_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 4,
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned BUS_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_start_i,
  output logic             rd_busy_o,
  output logic             req_o,
  output logic             atomic_o,
  input  logic             ack_i,
  input  logic [BUS_W-1:0] count_i,
  output logic             val_valid_o,
  output logic [CNT_W-1:0] val_o,
  output logic [CNT_W-1:0] delta_o,
  output logic             err_o
);

  import counter_rd_pkg::*;

  state_e           state_r;
  state_e           next_s;
  logic [BUS_W-1:0] lo_r;
  logic [CNT_W-1:0] snap_s;
  logic             timer_clear_s;
  logic             timer_en_s;
  logic             timer_expire_s;

  assign snap_s     = {count_i, lo_r};
  assign timer_en_s = ((state_r == WAIT_LO) || (state_r == WAIT_HI)) && !ack_i;

  ack_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .expire (timer_expire_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // An ack arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    next_s        = state_r;
    timer_clear_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_start_i) begin
          next_s = REQ_LO;
        end else begin
          next_s = IDLE;
        end
      end
      REQ_LO: begin
        timer_clear_s = 1'b1;
        next_s        = WAIT_LO;
      end
      WAIT_LO: begin
        if (ack_i) begin
          next_s = REQ_HI;
        end else if (timer_expire_s) begin
          next_s = ERR;
        end else begin
          next_s = WAIT_LO;
        end
      end
      REQ_HI: begin
        timer_clear_s = 1'b1;
        next_s        = WAIT_HI;
      end
      WAIT_HI: begin
        if (ack_i) begin
          next_s = DONE;
        end else if (timer_expire_s) begin
          next_s = ERR;
        end else begin
          next_s = WAIT_HI;
        end
      end
      DONE:    next_s = IDLE;
      ERR:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Outputs decode the next state so each pulse lines up with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_o       <= 1'b0;
      atomic_o    <= 1'b0;
      rd_busy_o   <= 1'b0;
      val_valid_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      req_o       <= (next_s == REQ_LO) || (next_s == REQ_HI);
      atomic_o    <= (next_s == REQ_LO);
      rd_busy_o   <= (next_s != IDLE);
      val_valid_o <= (next_s == DONE);
      err_o       <= (next_s == ERR);
    end
  end

  // val_o doubles as the previous good value, so delta is taken against it directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_r    <= '0;
      val_o   <= '0;
      delta_o <= '0;
    end else begin
      if ((state_r == WAIT_LO) && ack_i) begin
        lo_r <= count_i;
      end else begin
        lo_r <= lo_r;
      end
      if ((state_r == WAIT_HI) && ack_i) begin
        val_o   <= snap_s;
        delta_o <= snap_s - val_o;
      end else begin
        val_o   <= val_o;
        delta_o <= delta_o;
      end
    end
  end

endmodule

// File: tb/tb_counter_read_ctrl.sv
// Self-checking bench: transaction-level schedule model of the read master plus a counter responder.
module tb_counter_read_ctrl;

  localparam int TO    = 4;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_start_i;
  logic        rd_busy_o;
  logic        req_o;
  logic        atomic_o;
  logic        ack_i;
  logic [31:0] count_i;
  logic        val_valid_o;
  logic [63:0] val_o;
  logic [63:0] delta_o;
  logic        err_o;

  counter_read_ctrl #(
    .ACK_TIMEOUT (TO),
    .CNT_W       (64),
    .BUS_W       (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_start_i  (rd_start_i),
    .rd_busy_o   (rd_busy_o),
    .req_o       (req_o),
    .atomic_o    (atomic_o),
    .ack_i       (ack_i),
    .count_i     (count_i),
    .val_valid_o (val_valid_o),
    .val_o       (val_o),
    .delta_o     (delta_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int vecs  = 0;
  int fails = 0;
  int cyc   = 0;

  // counter under read
  logic [63:0] cnt     = 64'd0;
  logic [63:0] cnt_inc = 64'd0;

  // model of the read master at transaction level
  int          free_at  = 0;
  int          busy_lo  = -10;
  int          busy_hi  = -10;
  int          pend_r0  = -1;
  int          pend_r1  = -1;
  int          pend_end = -1;
  int          pend_dlo = 1;
  int          pend_dhi = 1;
  int          cfg_dlo  = 1;
  int          cfg_dhi  = 1;
  logic [63:0] model_prev = 64'd0;
  logic [63:0] model_val  = 64'd0;
  logic [63:0] model_del  = 64'd0;

  bit          exp_req  [int];
  bit          exp_err  [int];
  logic [63:0] exp_val  [int];
  logic [63:0] exp_del  [int];
  logic [31:0] ack_data [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // A start accepted at the end of cycle c: lay out the whole read's timeline.
  task automatic accept(input int c);
    int r0;
    int r1;
    int fin;
    r0 = c + 1;
    pend_dlo = cfg_dlo;
    pend_dhi = cfg_dhi;
    exp_req[r0] = 1'b1;
    r1 = -1;
    if (pend_dlo > TO) begin
      fin = r0 + TO + 1;
      exp_err[fin] = 1'b1;
    end else begin
      r1 = r0 + pend_dlo + 1;
      exp_req[r1] = 1'b0;
      if (pend_dhi > TO) begin
        fin = r1 + TO + 1;
        exp_err[fin] = 1'b1;
      end else begin
        fin = r1 + pend_dhi + 1;
      end
    end
    pend_r0  = r0;
    pend_r1  = r1;
    pend_end = fin;
    busy_lo  = c;
    busy_hi  = fin;
    free_at  = fin + 1;
  endtask

  // At the atomic beat the counter snapshots its value; both responses derive from it.
  task automatic fill_snapshot();
    logic [63:0] v;
    v = cnt;
    if (pend_dlo <= TO + 2) ack_data[pend_r0 + pend_dlo] = v[31:0];
    if (pend_dlo <= TO) begin
      if (pend_dhi <= TO + 2) ack_data[pend_r1 + pend_dhi] = v[63:32];
      if (pend_dhi <= TO) begin
        exp_val[pend_end] = v;
        exp_del[pend_end] = v - model_prev;
        model_prev = v;
      end
    end
  endtask

  task automatic check_cycle();
    bit          e_req;
    bit          e_atm;
    bit          e_busy;
    e_req  = exp_req.exists(cyc);
    e_atm  = e_req ? exp_req[cyc] : 1'b0;
    e_busy = (cyc > busy_lo) && (cyc <= busy_hi);
    check("req",    {63'd0, req_o},       {63'd0, e_req});
    check("atomic", {63'd0, atomic_o},    {63'd0, e_atm});
    check("valid",  {63'd0, val_valid_o}, {63'd0, exp_val.exists(cyc)});
    check("err",    {63'd0, err_o},       {63'd0, exp_err.exists(cyc)});
    check("busy",   {63'd0, rd_busy_o},   {63'd0, e_busy});
    check("val",    val_o,   model_val);
    check("delta",  delta_o, model_del);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset && rd_start_i && (cyc >= free_at)) accept(cyc);
    cyc++;
    #1;
    cnt = cnt + cnt_inc;
    if (cyc == pend_r0) fill_snapshot();
    ack_i   = ack_data.exists(cyc);
    count_i = ack_i ? ack_data[cyc] : 32'($urandom);
    if (exp_val.exists(cyc)) begin
      model_val = exp_val[cyc];
      model_del = exp_del[cyc];
    end
    check_cycle();
  endtask

  task automatic do_read(input int dlo, input int dhi);
    cfg_dlo    = dlo;
    cfg_dhi    = dhi;
    rd_start_i = 1'b1;
    tick();
    rd_start_i = 1'b0;
    for (int i = 0; (i < 40) && (cyc <= busy_hi); i++) tick();
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7)       return int'($urandom_range(1, 4));
    else if (r == 7) return 5;
    else if (r == 8) return 6;
    else             return NEVER;
  endfunction

  task automatic clear_model();
    exp_req.delete();
    exp_err.delete();
    exp_val.delete();
    exp_del.delete();
    ack_data.delete();
    pend_r0    = -1;
    pend_r1    = -1;
    busy_lo    = -10;
    busy_hi    = -10;
    model_prev = 64'd0;
    model_val  = 64'd0;
    model_del  = 64'd0;
  endtask

  initial begin
    int pulses;
    reset      = 1'b1;
    rd_start_i = 1'b0;
    ack_i      = 1'b0;
    count_i    = 32'd0;
    #1;
    check_cycle();
    repeat (2) tick();
    reset   = 1'b0;
    free_at = cyc;
    tick();

    // idle counter: first delta equals value, second is the difference
    cnt = 64'h10; cnt_inc = 64'd0;
    do_read(1, 1);
    check("t2_first_delta", delta_o, 64'h10);
    cnt = 64'h35;
    do_read(1, 1);
    check("t2_val", val_o, 64'h35);
    check("t2_delta", delta_o, 64'h25);

    // modulo-2^64 wrap of the delta
    cnt = 64'hFFFF_FFFF_FFFF_FFF0;
    do_read(1, 1);
    cnt = 64'h5;
    do_read(1, 1);
    check("t3_wrap_delta", delta_o, 64'h15);

    // running counter across a 32-bit carry: snapshot must never tear
    cnt = 64'h0000_0001_FFFF_FFFE - 64'd1; cnt_inc = 64'd1;
    for (int i = 0; i < 4; i++) do_read(1, 1);
    check("t1_hi_word", {32'd0, val_o[63:32]}, 64'h2);

    // timeouts, ack-on-expiry boundary and stray late acks
    do_read(NEVER, 1);
    check("t4_err_val_held", val_o, model_val);
    do_read(1, NEVER);
    do_read(4, 4);
    do_read(5, 1);
    do_read(2, 6);
    tick();

    // start held high: 6-cycle throughput, three completions inside the window
    cnt_inc = 64'd3;
    pulses  = 0;
    cfg_dlo = 1;
    cfg_dhi = 1;
    rd_start_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (val_valid_o === 1'b1) pulses++;
    end
    rd_start_i = 1'b0;
    check("t5_completions", 64'(pulses), 64'd3);
    for (int i = 0; (i < 40) && (cyc <= busy_hi); i++) tick();

    // randomized traffic, including starts while busy
    for (int i = 0; i < 400; i++) begin
      rd_start_i = ($urandom_range(0, 2) == 0);
      cfg_dlo    = pick_delay();
      cfg_dhi    = pick_delay();
      if ($urandom_range(0, 15) == 0) cnt = {32'($urandom), 32'($urandom)};
      cnt_inc = 64'($urandom_range(0, 40));
      tick();
    end
    rd_start_i = 1'b0;
    for (int i = 0; (i < 40) && (cyc <= busy_hi); i++) tick();

    // reset while waiting for the high beat
    cnt = 64'h0BAD_CAFE_0000_0001; cnt_inc = 64'd0;
    do_read(1, 1);
    cfg_dlo = 1;
    cfg_dhi = NEVER;
    rd_start_i = 1'b1;
    tick();
    rd_start_i = 1'b0;
    for (int i = 0; (i < 10) && (cyc < pend_r1 + 2); i++) tick();
    check("t6_in_wait_hi_busy", {63'd0, rd_busy_o}, 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_req_at_reset",   {63'd0, req_o},     64'd0);
    check("t6_busy_at_reset",  {63'd0, rd_busy_o}, 64'd0);
    check("t6_val_at_reset",   val_o,              64'd0);
    check("t6_delta_at_reset", delta_o,            64'd0);
    clear_model();
    repeat (2) tick();
    reset   = 1'b0;
    free_at = cyc;
    cnt = 64'h1234_5678_9ABC_DEF0;
    do_read(2, 3);
    check("t6_post_val",   val_o,   64'h1234_5678_9ABC_DEF0);
    check("t6_post_delta", delta_o, 64'h1234_5678_9ABC_DEF0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
